// File: rtl/sio_pad_ctrl_core_pkg.sv
// Purpose: shared types and constants for the SIO pad control core.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package sio_pad_ctrl_core_pkg;

  // Deepest programmable slew delay, in clk cycles.
  localparam int MAX_SLOW_DLY = 7;

  typedef enum logic [2:0] {
    DM_OFF           = 3'b000,
    DM_IN            = 3'b001,
    DM_PU_WEAK       = 3'b010,
    DM_STRONG1_WEAK0 = 3'b011,
    DM_OD_LO         = 3'b100,
    DM_OD_HI         = 3'b101,
    DM_STRONG        = 3'b110,
    DM_WEAK          = 3'b111
  } dm_e;

  // Pad driver leg enables.
  typedef struct packed {
    logic pu_strong;
    logic pu_weak;
    logic pd_strong;
    logic pd_weak;
  } legs_t;

  // One slot of the slew delay line: legs plus the fault that masked them.
  typedef struct packed {
    legs_t legs;
    logic  fault;
  } drv_tap_t;

  localparam legs_t LEGS_OFF = '0;

  // The driver is off when output enable is deasserted or the mode has no driver.
  function automatic logic is_tristate(input dm_e dm, input logic oe_n);
    return oe_n | (dm == DM_OFF) | (dm == DM_IN);
  endfunction

endpackage

// File: rtl/sio_drive_decode.sv
// Purpose: decode drive mode + output data into pad driver leg enables.
// Latency: combinational.
// Backpressure: none.
// Ports: dm (drive mode), out (output data), tristate (driver off) -> legs
//        {pu_strong, pu_weak, pd_strong, pd_weak}; at most one bit is ever set.
module sio_drive_decode
  import sio_pad_ctrl_core_pkg::*;
(
  input  logic [2:0] dm,
  input  logic       out,
  input  logic       tristate,
  output logic [3:0] legs
);

  legs_t leg;

  always_comb begin
    leg = LEGS_OFF;
    if (!tristate) begin
      case (dm_e'(dm))
        DM_PU_WEAK:       if (out) leg.pu_weak   = 1'b1; else leg.pd_strong = 1'b1;
        DM_STRONG1_WEAK0: if (out) leg.pu_strong = 1'b1; else leg.pd_weak   = 1'b1;
        DM_OD_LO:         if (!out) leg.pd_strong = 1'b1;
        DM_OD_HI:         if (out) leg.pu_strong = 1'b1;
        DM_STRONG:        if (out) leg.pu_strong = 1'b1; else leg.pd_strong = 1'b1;
        DM_WEAK:          if (out) leg.pu_weak   = 1'b1; else leg.pd_weak   = 1'b1;
        default:          leg = LEGS_OFF;
      endcase
    end
  end

  assign legs = leg;

endmodule

// File: rtl/sio_pad_ctrl_core.sv
// Purpose: SIO pad control core: config/drive capture with enable/hold rules,
//          driver leg decode, input buffer gating and fault flagging.
// Latency: config visible the cycle after capture; legs/pad_fault add SLOW_1_DELAY
//          or SLOW_0_DELAY extra cycles (chosen by slow_q); input path combinational.
// Backpressure: none; hold (hld_h_n=0) freezes registered state indefinitely.
// Ports: clk, rst_n (sync, active low); enable_h, hld_h_n, hld_ovr control capture;
//        dm/oe_n/out/inp_dis/slow/vtrip_sel/ibuf_sel/vreg_en are the captured config;
//        *_ok reference flags and pg_* power-good inputs qualify faults;
//        pad_in in; outputs: leg enables, pad_fault, in_h/in_lv with faults,
//        registered slow_q/vtrip_sel_q/ibuf_sel_q, vreg_warn, tie_lo.
module sio_pad_ctrl_core
  import sio_pad_ctrl_core_pkg::*;
#(
  parameter int unsigned SLOW_1_DELAY = 0,
  parameter int unsigned SLOW_0_DELAY = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_h,
  input  logic       hld_h_n,
  input  logic       hld_ovr,
  input  logic [2:0] dm,
  input  logic       oe_n,
  input  logic       out,
  input  logic       inp_dis,
  input  logic       slow,
  input  logic       vtrip_sel,
  input  logic       ibuf_sel,
  input  logic       vreg_en,
  input  logic       vinref_ok,
  input  logic       voutref_ok,
  input  logic       refleak_ok,
  input  logic       pg_hold,
  input  logic       pg_active,
  input  logic       pg_hold_ovr,
  input  logic       pg_out_drv,
  input  logic       pg_inbuf_hv,
  input  logic       pg_inbuf_lv,
  input  logic       pad_in,
  output logic       pu_strong,
  output logic       pu_weak,
  output logic       pd_strong,
  output logic       pd_weak,
  output logic       pad_fault,
  output logic       in_h,
  output logic       in_lv,
  output logic       in_fault,
  output logic       in_lv_fault,
  output logic       slow_q,
  output logic       vtrip_sel_q,
  output logic       ibuf_sel_q,
  output logic       vreg_warn,
  output logic       tie_lo
);

  localparam logic [2:0] SLOW1_DLY = 3'(SLOW_1_DELAY);
  localparam logic [2:0] SLOW0_DLY = 3'(SLOW_0_DELAY);

  dm_e  dm_q;
  logic inp_dis_q, hld_ovr_q, vreg_en_q, cfg_err;
  logic oe_n_q, out_q, drv_err;

  // Config and drive state. Power-good loss of the hold domain only raises the
  // error flags; the captured values stay put so the pad keeps its last state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dm_q        <= DM_OFF;
      inp_dis_q   <= 1'b0;
      vtrip_sel_q <= 1'b0;
      slow_q      <= 1'b0;
      hld_ovr_q   <= 1'b0;
      vreg_en_q   <= 1'b0;
      ibuf_sel_q  <= 1'b0;
      cfg_err     <= 1'b0;
      oe_n_q      <= 1'b0;
      out_q       <= 1'b0;
      drv_err     <= 1'b0;
    end else if (!pg_hold) begin
      cfg_err <= 1'b1;
      drv_err <= 1'b1;
    end else if (!enable_h) begin
      dm_q        <= DM_OFF;
      inp_dis_q   <= 1'b0;
      vtrip_sel_q <= 1'b0;
      slow_q      <= 1'b0;
      hld_ovr_q   <= 1'b0;
      vreg_en_q   <= 1'b0;
      ibuf_sel_q  <= 1'b0;
      cfg_err     <= 1'b0;
      oe_n_q      <= 1'b0;
      out_q       <= 1'b0;
      drv_err     <= 1'b0;
    end else begin
      if (hld_h_n) begin
        dm_q        <= dm_e'(dm);
        inp_dis_q   <= inp_dis;
        vtrip_sel_q <= vtrip_sel;
        slow_q      <= slow;
        hld_ovr_q   <= hld_ovr;
        vreg_en_q   <= vreg_en;
        ibuf_sel_q  <= ibuf_sel;
        cfg_err     <= !pg_active;
      end
      // The previously captured override lets oe_n/out track the core while
      // the rest of the configuration is held.
      if (hld_h_n || hld_ovr_q) begin
        oe_n_q  <= oe_n;
        out_q   <= out;
        drv_err <= !pg_hold_ovr;
      end
    end
  end

  logic     tristate, fault_now;
  logic [3:0] legs_raw;
  drv_tap_t cur_tap;

  assign tristate = is_tristate(dm_q, oe_n_q);

  sio_drive_decode u_drive_decode (
    .dm       (dm_q),
    .out      (out_q),
    .tristate (tristate),
    .legs     (legs_raw)
  );

  assign fault_now = !pg_out_drv
                   | (drv_err & !tristate)
                   | (cfg_err & !oe_n_q)
                   | (vreg_en_q & !tristate & !(voutref_ok & refleak_ok));

  // Masking happens before the delay line so every stored slot is already a
  // legal one-hot-or-zero leg vector; switching taps can never show two legs.
  always_comb begin
    cur_tap.fault = fault_now;
    cur_tap.legs  = fault_now ? LEGS_OFF : legs_t'(legs_raw);
  end

  drv_tap_t dly_q [1:MAX_SLOW_DLY];
  drv_tap_t taps  [0:MAX_SLOW_DLY];
  drv_tap_t sel_tap;
  logic [2:0] sel_dly;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i <= MAX_SLOW_DLY; i++) dly_q[i] <= '0;
    end else begin
      dly_q[1] <= cur_tap;
      for (int i = 2; i <= MAX_SLOW_DLY; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  // Tap 0 is the undelayed value straight off the registers.
  always_comb begin
    taps[0] = cur_tap;
    for (int i = 1; i <= MAX_SLOW_DLY; i++) taps[i] = dly_q[i];
  end

  assign sel_dly = slow_q ? SLOW1_DLY : SLOW0_DLY;
  assign sel_tap = taps[sel_dly];

  assign pu_strong = sel_tap.legs.pu_strong;
  assign pu_weak   = sel_tap.legs.pu_weak;
  assign pd_strong = sel_tap.legs.pd_strong;
  assign pd_weak   = sel_tap.legs.pd_weak;
  assign pad_fault = sel_tap.fault;

  // Input path.
  logic dm_on;
  assign dm_on       = (dm_q != DM_OFF);
  assign in_fault    = !pg_inbuf_hv
                     | (cfg_err & dm_on)
                     | (ibuf_sel_q & !inp_dis_q & dm_on & !vinref_ok);
  assign in_h        = !in_fault & dm_on & !inp_dis_q & pad_in;
  assign in_lv       = pg_inbuf_lv & in_h;
  assign in_lv_fault = in_fault | !pg_inbuf_lv;

  assign vreg_warn = vreg_en_q & !((dm_q == DM_STRONG1_WEAK0) | (dm_q == DM_OD_HI) | (dm_q == DM_STRONG));
  assign tie_lo    = 1'b0;

endmodule

// File: tb/tb_sio_pad_ctrl_core.sv
// Purpose: self-checking bench for sio_pad_ctrl_core: directed steps, then random
//          stimulus compared every cycle against a behavioural model.
// Latency: model predicts outputs 1 ns after each rising edge.
// Backpressure: n/a.
module tb_sio_pad_ctrl_core;

  localparam int SLOW1 = 3;
  localparam int SLOW0 = 0;

  // Leg codes as {pu_strong, pu_weak, pd_strong, pd_weak}.
  localparam logic [3:0] PUS = 4'b1000;
  localparam logic [3:0] PUW = 4'b0100;
  localparam logic [3:0] PDS = 4'b0010;
  localparam logic [3:0] PDW = 4'b0001;
  localparam logic [3:0] NON = 4'b0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, enable_h, hld_h_n, hld_ovr, oe_n, out, inp_dis, slow, vtrip_sel;
  logic ibuf_sel, vreg_en, vinref_ok, voutref_ok, refleak_ok;
  logic pg_hold, pg_active, pg_hold_ovr, pg_out_drv, pg_inbuf_hv, pg_inbuf_lv, pad_in;
  logic [2:0] dm;
  logic pu_strong, pu_weak, pd_strong, pd_weak, pad_fault, in_h, in_lv, in_fault, in_lv_fault;
  logic slow_q, vtrip_sel_q, ibuf_sel_q, vreg_warn, tie_lo;

  sio_pad_ctrl_core #(.SLOW_1_DELAY(SLOW1), .SLOW_0_DELAY(SLOW0)) dut (
    .clk(clk), .rst_n(rst_n), .enable_h(enable_h), .hld_h_n(hld_h_n), .hld_ovr(hld_ovr),
    .dm(dm), .oe_n(oe_n), .out(out), .inp_dis(inp_dis), .slow(slow), .vtrip_sel(vtrip_sel),
    .ibuf_sel(ibuf_sel), .vreg_en(vreg_en), .vinref_ok(vinref_ok), .voutref_ok(voutref_ok),
    .refleak_ok(refleak_ok), .pg_hold(pg_hold), .pg_active(pg_active), .pg_hold_ovr(pg_hold_ovr),
    .pg_out_drv(pg_out_drv), .pg_inbuf_hv(pg_inbuf_hv), .pg_inbuf_lv(pg_inbuf_lv), .pad_in(pad_in),
    .pu_strong(pu_strong), .pu_weak(pu_weak), .pd_strong(pd_strong), .pd_weak(pd_weak),
    .pad_fault(pad_fault), .in_h(in_h), .in_lv(in_lv), .in_fault(in_fault),
    .in_lv_fault(in_lv_fault), .slow_q(slow_q), .vtrip_sel_q(vtrip_sel_q),
    .ibuf_sel_q(ibuf_sel_q), .vreg_warn(vreg_warn), .tie_lo(tie_lo)
  );

  wire [3:0] legs_obs = {pu_strong, pu_weak, pd_strong, pd_weak};

  int checks = 0;
  int errors = 0;

  // Leg lookup indexed by {dm, out}.
  logic [3:0] leg_tab [16] = '{NON, NON, NON, NON, PDS, PUW, PDW, PUS,
                               PDS, NON, NON, PUS, PDS, PUS, PDW, PUW};

  // Model state.
  int   m_dm;
  logic m_inp_dis, m_vtrip, m_slow, m_hovr, m_vreg, m_ibuf, m_cfg_err;
  logic m_oe_n, m_out, m_drv_err;
  logic [4:0] hist [$];   // undelayed {legs, fault} per cycle, newest last

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] model_cur();
    logic tri_s, flt;
    logic [3:0] lg;
    tri_s = m_oe_n || (m_dm < 2);
    flt = !pg_out_drv || (m_drv_err && !tri_s) || (m_cfg_err && !m_oe_n)
          || (m_vreg && !tri_s && !(voutref_ok && refleak_ok));
    lg = (tri_s || flt) ? NON : leg_tab[m_dm * 2 + int'(m_out)];
    return {lg, flt};
  endfunction

  task automatic model_step();
    logic cap_drv;
    cap_drv = hld_h_n || m_hovr;
    if (!rst_n || (pg_hold && !enable_h)) begin
      m_dm = 0; {m_inp_dis, m_vtrip, m_slow, m_hovr, m_vreg, m_ibuf, m_cfg_err} = '0;
      {m_oe_n, m_out, m_drv_err} = '0;
    end else if (!pg_hold) begin
      m_cfg_err = 1'b1; m_drv_err = 1'b1;
    end else begin
      if (hld_h_n) begin
        m_dm = int'(dm); m_inp_dis = inp_dis; m_vtrip = vtrip_sel; m_slow = slow;
        m_hovr = hld_ovr; m_vreg = vreg_en; m_ibuf = ibuf_sel; m_cfg_err = !pg_active;
      end
      if (cap_drv) begin
        m_oe_n = oe_n; m_out = out; m_drv_err = !pg_hold_ovr;
      end
    end
  endtask

  // One clock: predict, advance, then compare every output against the model.
  task automatic cyc();
    logic [4:0] pre, now, exp;
    logic e_inf, e_inh, dm_on;
    int d;
    pre = model_cur();
    if (!rst_n) begin
      hist.delete();
      repeat (7) hist.push_back(5'd0);
    end else begin
      hist.push_back(pre);
      if (hist.size() > 16) void'(hist.pop_front());
    end
    model_step();
    @(posedge clk);
    #1;
    now = model_cur();
    d = m_slow ? SLOW1 : SLOW0;
    exp = (d == 0) ? now : hist[hist.size() - d];
    dm_on = (m_dm != 0);
    e_inf = !pg_inbuf_hv || (m_cfg_err && dm_on) || (m_ibuf && !m_inp_dis && dm_on && !vinref_ok);
    e_inh = !e_inf && dm_on && !m_inp_dis && pad_in;
    chk("legs", {4'd0, legs_obs}, {4'd0, exp[4:1]});
    chk("pad_fault", {7'd0, pad_fault}, {7'd0, exp[0]});
    chk("one_leg", {7'd0, ($countones(legs_obs) <= 1)}, 8'd1);
    chk("inbuf", {4'd0, in_h, in_lv, in_fault, in_lv_fault},
        {4'd0, e_inh, pg_inbuf_lv && e_inh, e_inf, e_inf || !pg_inbuf_lv});
    chk("cfg", {3'd0, slow_q, vtrip_sel_q, ibuf_sel_q, vreg_warn, tie_lo},
        {3'd0, m_slow, m_vtrip, m_ibuf, m_vreg && !(m_dm inside {3, 5, 6}), 1'b0});
  endtask

  task automatic set_idle();
    rst_n = 1; enable_h = 1; hld_h_n = 1; hld_ovr = 0; dm = 3'd0; oe_n = 0; out = 0;
    inp_dis = 0; slow = 0; vtrip_sel = 0; ibuf_sel = 0; vreg_en = 0;
    vinref_ok = 1; voutref_ok = 1; refleak_ok = 1; pad_in = 0;
    pg_hold = 1; pg_active = 1; pg_hold_ovr = 1; pg_out_drv = 1; pg_inbuf_hv = 1; pg_inbuf_lv = 1;
  endtask

  task automatic set_random();
    rst_n = ($urandom_range(0, 63) != 0);
    enable_h = ($urandom_range(0, 15) != 0);
    hld_h_n = ($urandom_range(0, 3) != 0);
    hld_ovr = 1'($urandom); dm = 3'($urandom); oe_n = 1'($urandom); out = 1'($urandom);
    inp_dis = 1'($urandom); slow = ($urandom_range(0, 7) == 0) ? ~slow : slow;
    vtrip_sel = 1'($urandom); ibuf_sel = 1'($urandom); vreg_en = 1'($urandom);
    pad_in = 1'($urandom);
    vinref_ok = ($urandom_range(0, 7) != 0); voutref_ok = ($urandom_range(0, 7) != 0);
    refleak_ok = ($urandom_range(0, 7) != 0);
    pg_hold = ($urandom_range(0, 15) != 0); pg_active = ($urandom_range(0, 15) != 0);
    pg_hold_ovr = ($urandom_range(0, 15) != 0); pg_out_drv = ($urandom_range(0, 15) != 0);
    pg_inbuf_hv = ($urandom_range(0, 15) != 0); pg_inbuf_lv = ($urandom_range(0, 15) != 0);
  endtask

  initial begin
    m_dm = 0;
    {m_inp_dis, m_vtrip, m_slow, m_hovr, m_vreg, m_ibuf, m_cfg_err, m_oe_n, m_out, m_drv_err} = '0;
    repeat (7) hist.push_back(5'd0);

    // Reset state.
    set_idle(); rst_n = 0;
    cyc(); cyc();
    chk("rst_legs", {4'd0, legs_obs}, {4'd0, NON});
    chk("rst_fault", {7'd0, pad_fault}, 8'd0);
    chk("rst_in_h", {7'd0, in_h}, 8'd0);

    // Strong drive high then low.
    rst_n = 1; dm = 3'b110; out = 1; cyc();
    chk("drv_hi", {4'd0, legs_obs}, {4'd0, PUS});
    out = 0; cyc();
    chk("drv_lo", {4'd0, legs_obs}, {4'd0, PDS});

    // Hold freezes everything.
    out = 1; cyc();
    hld_h_n = 0; cyc();
    dm = 3'b000; out = 0; cyc();
    chk("hold_legs", {4'd0, legs_obs}, {4'd0, PUS});

    // Hold override captured: out follows, dm stays strong.
    hld_h_n = 1; hld_ovr = 1; dm = 3'b110; out = 1; cyc();
    hld_h_n = 0; dm = 3'b000; out = 0; cyc();
    chk("hovr_legs", {4'd0, legs_obs}, {4'd0, PDS});
    hld_h_n = 1; hld_ovr = 0; dm = 3'b110; out = 1; cyc();

    // pg_active low at capture -> cfg error faults the driving pad.
    pg_active = 0; cyc();
    chk("cfgerr_fault", {7'd0, pad_fault}, 8'd1);
    chk("cfgerr_legs", {4'd0, legs_obs}, {4'd0, NON});
    enable_h = 0; cyc();
    chk("dis_fault", {7'd0, pad_fault}, 8'd0);
    chk("dis_legs", {4'd0, legs_obs}, {4'd0, NON});

    // Input buffer.
    enable_h = 1; pg_active = 1; dm = 3'b001; oe_n = 1; pad_in = 1; cyc();
    chk("in_h_on", {7'd0, in_h}, 8'd1);
    inp_dis = 1; cyc();
    chk("in_h_dis", {7'd0, in_h}, 8'd0);
    inp_dis = 0; ibuf_sel = 1; vinref_ok = 0; cyc();
    chk("in_fault_ref", {7'd0, in_fault}, 8'd1);
    ibuf_sel = 0; vinref_ok = 1; pg_inbuf_lv = 0; cyc();
    chk("in_lv_fault", {7'd0, in_lv_fault}, 8'd1);
    pg_inbuf_lv = 1;

    // Slew delay: 3 cycles with slow=1, immediate with slow=0.
    dm = 3'b110; oe_n = 0; out = 1; slow = 1;
    repeat (4) cyc();
    chk("slow_settle", {4'd0, legs_obs}, {4'd0, PUS});
    out = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("slow_wait", {4'd0, legs_obs}, {4'd0, PUS});
    end
    cyc();
    chk("slow_change", {4'd0, legs_obs}, {4'd0, PDS});
    slow = 0; out = 1; cyc();
    chk("fast_change", {4'd0, legs_obs}, {4'd0, PUS});

    // Regulated drive checks.
    vreg_en = 1; dm = 3'b010; cyc();
    chk("vreg_warn", {7'd0, vreg_warn}, 8'd1);
    dm = 3'b011; voutref_ok = 0; cyc();
    chk("vreg_fault", {7'd0, pad_fault}, 8'd1);
    chk("vreg_nowarn", {7'd0, vreg_warn}, 8'd0);

    // Random phase.
    for (int n = 0; n < 800; n++) begin
      set_random();
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
